// File: rtl/dma_rd_arb.sv
// dma_rd_arb
// ----------
// Read-side arbiter that shares one AXI DMA read port between NUM_CH
// buffer-manager clients. Each client owns a one-deep descriptor holding
// register. A single FSM grants one pending client at a time, issues its
// descriptor to the DMA, and routes the returned stream to that client.
//
// Handshake rule used on every interface here: a transfer happens on a
// rising clk edge where valid && ready are both high. A source keeps valid
// and its payload stable until that edge. A sink may raise or drop ready
// freely.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ch_desc_*           per-client descriptor request (addr/len/valid/ready),
//                       client i at slice [i*W +: W]
//   ch_rd_t*            stream toward the clients: data/keep/last are shared,
//                       tvalid is one-hot toward the granted client,
//                       tready is per client
//   ch_done             one-cycle pulse to the client whose transfer ended
//   enable              DMA enable, high while a descriptor is in flight
//   desc_*              descriptor port toward the DMA core
//   read_data_t*        stream from the DMA core
//   busy                FSM not idle, or any holding register occupied
//   state_dbg           current FSM state (0 idle, 1 issue, 2 stream, 3 done)

module dma_rd_arb #(
    parameter int NUM_CH = 6,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 20,
    parameter int DATA_W = 512,
    parameter int KEEP_W = DATA_W / 8,
    parameter int RR_EN  = 0
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [NUM_CH*ADDR_W-1:0]   ch_desc_addr,
    input  logic [NUM_CH*LEN_W-1:0]    ch_desc_len,
    input  logic [NUM_CH-1:0]          ch_desc_valid,
    output logic [NUM_CH-1:0]          ch_desc_ready,

    output logic [DATA_W-1:0]          ch_rd_tdata,
    output logic [KEEP_W-1:0]          ch_rd_tkeep,
    output logic                       ch_rd_tlast,
    output logic [NUM_CH-1:0]          ch_rd_tvalid,
    input  logic [NUM_CH-1:0]          ch_rd_tready,
    output logic [NUM_CH-1:0]          ch_done,

    output logic                       enable,
    output logic [ADDR_W-1:0]          desc_addr,
    output logic [LEN_W-1:0]           desc_len,
    output logic                       desc_valid,
    input  logic                       desc_ready,

    input  logic [DATA_W-1:0]          read_data_tdata,
    input  logic [KEEP_W-1:0]          read_data_tkeep,
    input  logic                       read_data_tvalid,
    output logic                       read_data_tready,
    input  logic                       read_data_tlast,

    output logic                       busy,
    output logic [1:0]                 state_dbg
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [NUM_CH-1:0]  pend;
    logic [ADDR_W-1:0]  hold_addr [NUM_CH];
    logic [LEN_W-1:0]   hold_len  [NUM_CH];

    logic [IDX_W-1:0]   grant;      // client owning the current transfer
    logic [IDX_W-1:0]   ptr;        // round-robin search start
    logic [IDX_W-1:0]   sel;        // arbiter choice this cycle
    logic               sel_found;
    logic [IDX_W:0]     cand;       // one spare bit so ptr+k never overflows
    logic               sel_zero_len;

    // ------------------------------------------------------------------
    // Arbiter: picks among pending clients. Only consumed in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        cand      = '0;
        if (RR_EN != 0) begin
            // Scan NUM_CH slots starting at ptr, wrapping modulo NUM_CH.
            for (int k = 0; k < NUM_CH; k++) begin
                cand = {1'b0, ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_CH)) begin
                    cand = cand - (IDX_W+1)'(NUM_CH);
                end
                if (!sel_found && pend[cand[IDX_W-1:0]]) begin
                    sel       = cand[IDX_W-1:0];
                    sel_found = 1'b1;
                end
            end
        end else begin
            // Descending scan so the lowest pending index is written last.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (pend[k]) begin
                    sel       = IDX_W'(k);
                    sel_found = 1'b1;
                end
            end
        end
    end

    assign sel_zero_len = (hold_len[sel] == '0);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (sel_found) begin
                    // A zero-length request never reaches the DMA core.
                    state_nxt = sel_zero_len ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (desc_valid && desc_ready) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (read_data_tvalid && read_data_tready && read_data_tlast) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding registers: payload only, validity lives in pend.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_desc_valid[i] && !pend[i]) begin
                hold_addr[i] <= ch_desc_addr[i*ADDR_W +: ADDR_W];
                hold_len[i]  <= ch_desc_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pend bits, grant, RR pointer and the registered descriptor port.
    // A client can only be accepted while its pend bit is clear and it
    // can only be granted while the bit is set, so set and clear never
    // hit the same bit on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            grant      <= '0;
            ptr        <= '0;
            desc_valid <= 1'b0;
            desc_addr  <= '0;
            desc_len   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_desc_valid[i] && !pend[i]) begin
                    pend[i] <= 1'b1;
                end
            end

            if (state == S_IDLE && sel_found) begin
                pend[sel] <= 1'b0;
                grant     <= sel;
                if (RR_EN != 0) begin
                    ptr <= (sel == IDX_W'(NUM_CH - 1)) ? '0 : sel + IDX_W'(1);
                end
                if (!sel_zero_len) begin
                    desc_valid <= 1'b1;
                    desc_addr  <= hold_addr[sel];
                    desc_len   <= hold_len[sel];
                end
            end

            if (state == S_ISSUE && desc_ready) begin
                desc_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stream routing: zero-latency, only the granted client sees valid,
    // and the DMA only sees ready while streaming.
    // ------------------------------------------------------------------
    assign ch_rd_tdata = read_data_tdata;
    assign ch_rd_tkeep = read_data_tkeep;
    assign ch_rd_tlast = read_data_tlast;

    always_comb begin
        ch_rd_tvalid     = '0;
        ch_done          = '0;
        read_data_tready = 1'b0;
        if (state == S_STREAM) begin
            read_data_tready = ch_rd_tready[grant];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == IDX_W'(i)) begin
                ch_rd_tvalid[i] = (state == S_STREAM) && read_data_tvalid;
                ch_done[i]      = (state == S_DONE);
            end
        end
    end

    assign ch_desc_ready = ~pend;
    assign enable        = (state == S_ISSUE) || (state == S_STREAM);
    assign busy          = (state != S_IDLE) || (|pend);
    assign state_dbg     = state;

endmodule

// File: tb/tb_dma_rd_arb.sv
// Directed bench for dma_rd_arb. Two instances share every input: u_fp
// uses fixed priority and u_rr uses round-robin. Each scenario starts from
// reset and only observes the instance it targets.

module tb_dma_rd_arb;

  localparam int NUM_CH = 6;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 20;
  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic [NUM_CH*ADDR_W-1:0] ch_desc_addr;
  logic [NUM_CH*LEN_W-1:0]  ch_desc_len;
  logic [NUM_CH-1:0]        ch_desc_valid;
  logic [NUM_CH-1:0]        ch_rd_tready;
  logic                     desc_ready;
  logic [DATA_W-1:0]        read_data_tdata;
  logic [KEEP_W-1:0]        read_data_tkeep;
  logic                     read_data_tvalid;
  logic                     read_data_tlast;

  // ---------------- fixed-priority instance outputs ----------------
  logic [NUM_CH-1:0] fp_ch_desc_ready, fp_ch_rd_tvalid, fp_ch_done;
  logic [DATA_W-1:0] fp_ch_rd_tdata;
  logic [KEEP_W-1:0] fp_ch_rd_tkeep;
  logic              fp_ch_rd_tlast, fp_enable, fp_desc_valid, fp_read_data_tready, fp_busy;
  logic [ADDR_W-1:0] fp_desc_addr;
  logic [LEN_W-1:0]  fp_desc_len;
  logic [1:0]        fp_state_dbg;

  // ---------------- round-robin instance outputs ----------------
  logic [NUM_CH-1:0] rr_ch_desc_ready, rr_ch_rd_tvalid, rr_ch_done;
  logic [DATA_W-1:0] rr_ch_rd_tdata;
  logic [KEEP_W-1:0] rr_ch_rd_tkeep;
  logic              rr_ch_rd_tlast, rr_enable, rr_desc_valid, rr_read_data_tready, rr_busy;
  logic [ADDR_W-1:0] rr_desc_addr;
  logic [LEN_W-1:0]  rr_desc_len;
  logic [1:0]        rr_state_dbg;

  dma_rd_arb #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
               .KEEP_W(KEEP_W), .RR_EN(0)) u_fp (
    .clk(clk), .rst(rst),
    .ch_desc_addr(ch_desc_addr), .ch_desc_len(ch_desc_len),
    .ch_desc_valid(ch_desc_valid), .ch_desc_ready(fp_ch_desc_ready),
    .ch_rd_tdata(fp_ch_rd_tdata), .ch_rd_tkeep(fp_ch_rd_tkeep), .ch_rd_tlast(fp_ch_rd_tlast),
    .ch_rd_tvalid(fp_ch_rd_tvalid), .ch_rd_tready(ch_rd_tready), .ch_done(fp_ch_done),
    .enable(fp_enable), .desc_addr(fp_desc_addr), .desc_len(fp_desc_len),
    .desc_valid(fp_desc_valid), .desc_ready(desc_ready),
    .read_data_tdata(read_data_tdata), .read_data_tkeep(read_data_tkeep),
    .read_data_tvalid(read_data_tvalid), .read_data_tready(fp_read_data_tready),
    .read_data_tlast(read_data_tlast), .busy(fp_busy), .state_dbg(fp_state_dbg)
  );

  dma_rd_arb #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
               .KEEP_W(KEEP_W), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst),
    .ch_desc_addr(ch_desc_addr), .ch_desc_len(ch_desc_len),
    .ch_desc_valid(ch_desc_valid), .ch_desc_ready(rr_ch_desc_ready),
    .ch_rd_tdata(rr_ch_rd_tdata), .ch_rd_tkeep(rr_ch_rd_tkeep), .ch_rd_tlast(rr_ch_rd_tlast),
    .ch_rd_tvalid(rr_ch_rd_tvalid), .ch_rd_tready(ch_rd_tready), .ch_done(rr_ch_done),
    .enable(rr_enable), .desc_addr(rr_desc_addr), .desc_len(rr_desc_len),
    .desc_valid(rr_desc_valid), .desc_ready(desc_ready),
    .read_data_tdata(read_data_tdata), .read_data_tkeep(read_data_tkeep),
    .read_data_tvalid(read_data_tvalid), .read_data_tready(rr_read_data_tready),
    .read_data_tlast(read_data_tlast), .busy(rr_busy), .state_dbg(rr_state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after a rising edge; outputs are sampled there
  // (registered values) or at the falling edge (combinational paths).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    ch_desc_addr     = '0;
    ch_desc_len      = '0;
    ch_desc_valid    = '0;
    ch_rd_tready     = '1;
    desc_ready       = 1'b0;
    read_data_tdata  = '0;
    read_data_tkeep  = '0;
    read_data_tvalid = 1'b0;
    read_data_tlast  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    ch_desc_addr[ch*ADDR_W +: ADDR_W] = a;
    ch_desc_len[ch*LEN_W +: LEN_W]    = l;
    ch_desc_valid[ch]                 = 1'b1;
  endtask

  // Waits (bounded) until the selected instance shows desc_valid.
  task automatic wait_desc(input bit use_rr, output logic [ADDR_W-1:0] a,
                           output logic [LEN_W-1:0] l, output bit ok);
    ok = 1'b0;
    a  = '0;
    l  = '0;
    for (int c = 0; c < 40; c++) begin
      if ((use_rr ? rr_desc_valid : fp_desc_valid) === 1'b1) begin
        ok = 1'b1;
        a  = use_rr ? rr_desc_addr : fp_desc_addr;
        l  = use_rr ? rr_desc_len : fp_desc_len;
        break;
      end
      tick();
    end
  endtask

  // Acts as the DMA stream source (n beats, low word = base+beat) and as the
  // client sink on channel g, scoreboarding the beats the client receives.
  // Returns right after the edge that carried the tlast beat.
  task automatic run_stream(input bit use_rr, input int g, input int n, input bit toggle,
                            input logic [31:0] base, output int beats, output int bad_data,
                            output int bad_route, output bit ok);
    logic [31:0]       exp_q[$];
    logic [31:0]       e;
    logic [3:0]        pat;
    logic [NUM_CH-1:0] tv;
    logic              rdy;
    logic [DATA_W-1:0] td;
    bit                hs;
    int                sent;
    int                cyc;
    pat       = 4'b1001;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
    beats     = 0;
    bad_data  = 0;
    bad_route = 0;
    ok        = 1'b0;
    sent      = 0;
    cyc       = 0;
    while (!ok && cyc < 100) begin
      read_data_tvalid       = 1'b1;
      read_data_tdata        = '0;
      read_data_tdata[31:0]  = base + 32'(sent);
      read_data_tkeep        = '1;
      read_data_tlast        = (sent == n - 1);
      if (toggle) ch_rd_tready[g] = pat[cyc % 4];
      #4;
      rdy = use_rr ? rr_read_data_tready : fp_read_data_tready;
      tv  = use_rr ? rr_ch_rd_tvalid : fp_ch_rd_tvalid;
      td  = use_rr ? rr_ch_rd_tdata : fp_ch_rd_tdata;
      if (rdy !== ch_rd_tready[g]) bad_route++;
      if ((tv & ~(NUM_CH'(1) << g)) !== '0) bad_route++;
      if (tv[g] !== 1'b1) bad_route++;
      hs = read_data_tvalid && (rdy === 1'b1);
      if (tv[g] === 1'b1 && ch_rd_tready[g] === 1'b1) begin
        beats++;
        if (exp_q.size() == 0) begin
          bad_data++;
        end else begin
          e = exp_q.pop_front();
          if (td[31:0] !== e) bad_data++;
        end
      end
      tick();
      if (hs) begin
        if (sent == n - 1) ok = 1'b1;
        sent++;
      end
      cyc++;
    end
    read_data_tvalid = 1'b0;
    read_data_tlast  = 1'b0;
    ch_rd_tready     = '1;
    bad_data += exp_q.size();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (fp_desc_valid !== 1'b0 || fp_enable !== 1'b0 || fp_read_data_tready !== 1'b0 ||
        fp_desc_addr !== '0 || fp_desc_len !== '0 || fp_busy !== 1'b0 || fp_state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_fp valid=%0b en=%0b trdy=%0b addr=%0h len=%0h busy=%0b st=%0d exp all 0",
               fp_desc_valid, fp_enable, fp_read_data_tready, fp_desc_addr, fp_desc_len, fp_busy, fp_state_dbg);
    end
    checks++;
    if (fp_ch_rd_tvalid !== 6'b0 || fp_ch_done !== 6'b0 || fp_ch_desc_ready !== 6'b111111 ||
        rr_ch_desc_ready !== 6'b111111 || rr_desc_valid !== 1'b0 || rr_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_vec tvalid=%b done=%b fp_rdy=%b rr_rdy=%b rr_valid=%0b rr_en=%0b exp 0 0 111111 111111 0 0",
               fp_ch_rd_tvalid, fp_ch_done, fp_ch_desc_ready, rr_ch_desc_ready, rr_desc_valid, rr_enable);
    end
  endtask

  task automatic test_single();
    int beats, bd, br;
    bit ok;
    do_reset();
    desc_ready = 1'b1;
    set_req(2, 32'h1000, 20'd256);
    tick();
    ch_desc_valid = '0;
    checks++;
    if (fp_desc_valid !== 1'b0 || fp_ch_desc_ready !== 6'b111011 || fp_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_accept valid=%0b rdy=%b busy=%0b exp 0 111011 1",
               fp_desc_valid, fp_ch_desc_ready, fp_busy);
    end
    tick();
    checks++;
    if (fp_desc_valid !== 1'b1 || fp_desc_addr !== 32'h1000 || fp_desc_len !== 20'd256) begin
      errors++;
      $display("FAIL single_desc valid=%0b addr=%0h len=%0d exp 1 1000 256",
               fp_desc_valid, fp_desc_addr, fp_desc_len);
    end
    checks++;
    if (fp_enable !== 1'b1 || fp_ch_desc_ready !== 6'b111111 || fp_state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL single_grant en=%0b rdy=%b st=%0d exp 1 111111 1", fp_enable, fp_ch_desc_ready, fp_state_dbg);
    end
    tick();
    checks++;
    if (fp_desc_valid !== 1'b0 || fp_state_dbg !== 2'd2 || fp_enable !== 1'b1) begin
      errors++;
      $display("FAIL single_issue valid=%0b st=%0d en=%0b exp 0 2 1", fp_desc_valid, fp_state_dbg, fp_enable);
    end
    run_stream(1'b0, 2, 4, 1'b0, 32'hC000, beats, bd, br, ok);
    checks++;
    if (!ok || beats != 4 || bd != 0 || br != 0) begin
      errors++;
      $display("FAIL single_stream ok=%0b beats=%0d bad_data=%0d bad_route=%0d exp 1 4 0 0", ok, beats, bd, br);
    end
    checks++;
    if (fp_ch_done !== 6'b000100 || fp_enable !== 1'b0 || fp_read_data_tready !== 1'b0) begin
      errors++;
      $display("FAIL single_done done=%b en=%0b trdy=%0b exp 000100 0 0", fp_ch_done, fp_enable, fp_read_data_tready);
    end
    tick();
    checks++;
    if (fp_ch_done !== 6'b0 || fp_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle done=%b busy=%0b exp 0 0", fp_ch_done, fp_busy);
    end
  endtask

  task automatic test_fixed_prio();
    int order[3] = '{1, 3, 5};
    logic [ADDR_W-1:0] a;
    logic [LEN_W-1:0]  l;
    int beats, bd, br;
    bit ok, sok;
    do_reset();
    desc_ready = 1'b1;
    set_req(5, 32'h5000, 20'd64);
    set_req(1, 32'h1000, 20'd64);
    set_req(3, 32'h3000, 20'd64);
    tick();
    ch_desc_valid = '0;
    checks++;
    if (fp_ch_desc_ready !== 6'b010101) begin
      errors++;
      $display("FAIL prio_accept rdy=%b exp 010101", fp_ch_desc_ready);
    end
    for (int i = 0; i < 3; i++) begin
      wait_desc(1'b0, a, l, ok);
      checks++;
      if (!ok || a !== ADDR_W'(order[i] * 32'h1000) || l !== 20'd64) begin
        errors++;
        $display("FAIL prio_grant%0d ok=%0b addr=%0h len=%0d exp addr %0h len 64",
                 i, ok, a, l, order[i] * 32'h1000);
      end
      tick();
      run_stream(1'b0, order[i], 1, 1'b0, 32'h100 * i, beats, bd, br, sok);
      checks++;
      if (!sok || beats != 1 || bd != 0 || br != 0 || fp_ch_done !== (NUM_CH'(1) << order[i])) begin
        errors++;
        $display("FAIL prio_xfer%0d ok=%0b beats=%0d bd=%0d br=%0d done=%b exp ch %0d",
                 i, sok, beats, bd, br, fp_ch_done, order[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a;
    logic [LEN_W-1:0]  l;
    int beats, bd, br;
    bit ok, sok;
    do_reset();
    desc_ready = 1'b1;
    set_req(0, 32'h2000, 20'd512);
    tick();
    ch_desc_valid = '0;
    wait_desc(1'b0, a, l, ok);
    checks++;
    if (!ok || a !== 32'h2000 || l !== 20'd512) begin
      errors++;
      $display("FAIL bp_desc ok=%0b addr=%0h len=%0d exp 2000 512", ok, a, l);
    end
    tick();
    run_stream(1'b0, 0, 8, 1'b1, 32'h7700, beats, bd, br, sok);
    checks++;
    if (!sok || beats != 8 || bd != 0 || br != 0) begin
      errors++;
      $display("FAIL bp_stream ok=%0b beats=%0d bad_data=%0d bad_route=%0d exp 1 8 0 0", sok, beats, bd, br);
    end
    checks++;
    if (fp_ch_done !== 6'b000001) begin
      errors++;
      $display("FAIL bp_done done=%b exp 000001", fp_ch_done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    logic [LEN_W-1:0]  l;
    int beats, bd, br;
    bit ok, sok;
    do_reset();
    desc_ready = 1'b1;
    set_req(4, 32'h4000, 20'd128);
    tick();
    ch_desc_valid = '0;
    tick();
    checks++;
    if (fp_desc_valid !== 1'b1 || fp_desc_addr !== 32'h4000 || fp_ch_desc_ready[4] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_grant valid=%0b addr=%0h rdy4=%0b exp 1 4000 1", fp_desc_valid, fp_desc_addr, fp_ch_desc_ready[4]);
    end
    set_req(4, 32'h4400, 20'd64);
    tick();
    ch_desc_valid = '0;
    checks++;
    if (fp_ch_desc_ready[4] !== 1'b0 || fp_state_dbg !== 2'd2) begin
      errors++;
      $display("FAIL b2b_second rdy4=%0b st=%0d exp 0 2", fp_ch_desc_ready[4], fp_state_dbg);
    end
    set_req(4, 32'h4800, 20'd64);   // third request, held until accepted
    run_stream(1'b0, 4, 2, 1'b0, 32'h4000, beats, bd, br, sok);
    checks++;
    if (!sok || beats != 2 || bd != 0 || br != 0) begin
      errors++;
      $display("FAIL b2b_stream1 ok=%0b beats=%0d bd=%0d br=%0d exp 1 2 0 0", sok, beats, bd, br);
    end
    checks++;
    if (fp_ch_done !== 6'b010000 || fp_ch_desc_ready[4] !== 1'b0 || fp_desc_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done1 done=%b rdy4=%0b valid=%0b exp 010000 0 0", fp_ch_done, fp_ch_desc_ready[4], fp_desc_valid);
    end
    tick();
    checks++;
    if (fp_ch_desc_ready[4] !== 1'b0 || fp_desc_valid !== 1'b0 || fp_ch_done !== 6'b0) begin
      errors++;
      $display("FAIL b2b_idle rdy4=%0b valid=%0b done=%b exp 0 0 0", fp_ch_desc_ready[4], fp_desc_valid, fp_ch_done);
    end
    tick();
    checks++;
    if (fp_desc_valid !== 1'b1 || fp_desc_addr !== 32'h4400 || fp_desc_len !== 20'd64 || fp_ch_desc_ready[4] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_issue2 valid=%0b addr=%0h len=%0d rdy4=%0b exp 1 4400 64 1",
               fp_desc_valid, fp_desc_addr, fp_desc_len, fp_ch_desc_ready[4]);
    end
    tick();
    ch_desc_valid = '0;
    checks++;
    if (fp_ch_desc_ready[4] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_third_held rdy4=%0b exp 0", fp_ch_desc_ready[4]);
    end
    run_stream(1'b0, 4, 1, 1'b0, 32'h4400, beats, bd, br, sok);
    tick();
    wait_desc(1'b0, a, l, ok);
    checks++;
    if (!sok || beats != 1 || !ok || a !== 32'h4800) begin
      errors++;
      $display("FAIL b2b_issue3 stream_ok=%0b beats=%0d ok=%0b addr=%0h exp 1 1 1 4800", sok, beats, ok, a);
    end
    tick();
    run_stream(1'b0, 4, 1, 1'b0, 32'h4800, beats, bd, br, sok);
    tick();
    checks++;
    if (!sok || fp_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end ok=%0b busy=%0b exp 1 0", sok, fp_busy);
    end
  endtask

  task automatic test_zero_len();
    int seen;
    do_reset();
    desc_ready = 1'b1;
    set_req(1, 32'h9000, 20'd0);
    tick();
    ch_desc_valid = '0;
    seen = 0;
    tick();
    if (fp_desc_valid !== 1'b0) seen++;
    checks++;
    if (fp_ch_done !== 6'b000010 || fp_enable !== 1'b0 || fp_desc_valid !== 1'b0) begin
      errors++;
      $display("FAIL zlen_done done=%b en=%0b valid=%0b exp 000010 0 0", fp_ch_done, fp_enable, fp_desc_valid);
    end
    tick();
    if (fp_desc_valid !== 1'b0) seen++;
    tick();
    if (fp_desc_valid !== 1'b0) seen++;
    checks++;
    if (seen != 0 || fp_ch_done !== 6'b0 || fp_busy !== 1'b0) begin
      errors++;
      $display("FAIL zlen_after desc_seen=%0d done=%b busy=%0b exp 0 0 0", seen, fp_ch_done, fp_busy);
    end
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 3, 0, 3, 5, 0};
    logic [ADDR_W-1:0] a;
    logic [LEN_W-1:0]  l;
    int beats, bd, br;
    bit ok, sok;
    do_reset();
    desc_ready = 1'b1;
    set_req(0, 32'hA000, 20'd64);
    set_req(3, 32'hA300, 20'd64);
    for (int i = 0; i < 6; i++) begin
      wait_desc(1'b1, a, l, ok);
      if (i == 3) begin
        ch_desc_valid[0] = 1'b0;
        ch_desc_valid[3] = 1'b0;
        set_req(5, 32'hA500, 20'd64);
      end
      if (i == 4) ch_desc_valid[5] = 1'b0;
      checks++;
      if (!ok || a !== ADDR_W'(32'hA000 + order[i] * 32'h100)) begin
        errors++;
        $display("FAIL rr_grant%0d ok=%0b addr=%0h exp %0h", i, ok, a, 32'hA000 + order[i] * 32'h100);
      end
      tick();
      run_stream(1'b1, order[i], 1, 1'b0, 32'h500 + i, beats, bd, br, sok);
      checks++;
      if (!sok || beats != 1 || bd != 0 || br != 0 || rr_ch_done !== (NUM_CH'(1) << order[i])) begin
        errors++;
        $display("FAIL rr_xfer%0d ok=%0b beats=%0d bd=%0d br=%0d done=%b exp ch %0d",
                 i, sok, beats, bd, br, rr_ch_done, order[i]);
      end
      tick();
    end
    checks++;
    if (rr_busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle busy=%0b exp 0", rr_busy);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    desc_ready = 1'b1;
    set_req(3, 32'h3000, 20'd256);
    tick();
    ch_desc_valid = '0;
    tick();
    tick();
    set_req(2, 32'h2000, 20'd64);
    read_data_tvalid = 1'b1;
    read_data_tdata  = '0;
    read_data_tkeep  = '1;
    tick();
    ch_desc_valid = '0;
    checks++;
    if (fp_ch_rd_tvalid !== 6'b001000 || fp_ch_desc_ready !== 6'b111011 || fp_state_dbg !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_pre tvalid=%b rdy=%b st=%0d exp 001000 111011 2", fp_ch_rd_tvalid, fp_ch_desc_ready, fp_state_dbg);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (fp_desc_valid !== 1'b0 || fp_enable !== 1'b0 || fp_read_data_tready !== 1'b0 ||
        fp_ch_rd_tvalid !== 6'b0 || fp_ch_done !== 6'b0 || fp_desc_addr !== '0 || fp_desc_len !== '0) begin
      errors++;
      $display("FAIL rstmid_out valid=%0b en=%0b trdy=%0b tvalid=%b done=%b addr=%0h len=%0h exp all 0",
               fp_desc_valid, fp_enable, fp_read_data_tready, fp_ch_rd_tvalid, fp_ch_done, fp_desc_addr, fp_desc_len);
    end
    checks++;
    if (fp_ch_desc_ready !== 6'b111111 || fp_busy !== 1'b0 || fp_state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_pend rdy=%b busy=%0b st=%0d exp 111111 0 0", fp_ch_desc_ready, fp_busy, fp_state_dbg);
    end
    rst = 1'b0;
    read_data_tvalid = 1'b0;
    tick();
    tick();
    checks++;
    if (fp_desc_valid !== 1'b0 || fp_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after valid=%0b busy=%0b exp 0 0", fp_desc_valid, fp_busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_fixed_prio();
    test_backpressure();
    test_back_to_back();
    test_zero_len();
    test_round_robin();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog sim time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
